// File: rtl/riscv_mem_port_arb_pkg.sv
// Shared definitions for the fetch memory-port arbiter: requester tag encodings
// and the default tag-queue depth.
package riscv_mem_port_arb_pkg;

   localparam logic TAG_REQ0      = 1'b0;
   localparam logic TAG_REQ1      = 1'b1;
   localparam int   DEFAULT_DEPTH = 4;

endpackage

// File: rtl/riscv_mem_port_arb_tagq.sv
// Circular FIFO of 1-bit requester tags, one entry per outstanding memory request.
// Push is refused when full and pop is refused when empty, with no same-cycle bypass.
module riscv_mem_port_arb_tagq #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH+1)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          i_push,
   input  logic          i_tag,
   input  logic          i_pop,
   output logic          o_head,
   output logic          o_full,
   output logic          o_empty,
   output logic [CW-1:0] o_count
);
   localparam int PW = $clog2(DEPTH);

   logic          r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_tag;
   end

endmodule

// File: rtl/riscv_mem_port_arb.sv
// Merges the two fetch request streams onto one memory port and steers in-order
// responses back by tag. Define RISCV_MEM_PORT_ARB_FIXED_PRIO_EN for req0-wins ties.
module riscv_mem_port_arb
   import riscv_mem_port_arb_pkg::*;
#(
   parameter int REQ_SZ  = 67,
   parameter int RESP_SZ = 35,
   parameter int DEPTH   = DEFAULT_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [REQ_SZ-1:0]          req0_msg,
   input  logic                       req0_val,
   output logic                       req0_rdy,
   input  logic [REQ_SZ-1:0]          req1_msg,
   input  logic                       req1_val,
   output logic                       req1_rdy,
   output logic [RESP_SZ-1:0]         resp0_msg,
   output logic                       resp0_val,
   output logic [RESP_SZ-1:0]         resp1_msg,
   output logic                       resp1_val,
   output logic [REQ_SZ-1:0]          memreq_msg,
   output logic                       memreq_val,
   input  logic                       memreq_rdy,
   input  logic [RESP_SZ-1:0]         memresp_msg,
   input  logic                       memresp_val,
   output logic [$clog2(DEPTH+1)-1:0] inflight,
   output logic                       err_orphan
);
   localparam int CW = $clog2(DEPTH+1);

   logic          w_winner;
   logic          w_fire;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic          w_head;
   logic [CW-1:0] w_count;
   logic          r_err_orphan;

`ifdef RISCV_MEM_PORT_ARB_FIXED_PRIO_EN
   assign w_winner = ~req0_val & req1_val;
`else
   logic r_rr_ptr;

   always_comb begin
      w_winner = TAG_REQ0;
      if (req0_val && req1_val) w_winner = r_rr_ptr;
      else if (req1_val)        w_winner = TAG_REQ1;
   end

   // The pointer only moves on a contested grant so a lone requester never skews fairness.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                            r_rr_ptr <= 1'b0;
      else if (w_fire && req0_val && req1_val) r_rr_ptr <= ~w_winner;
   end
`endif

   assign memreq_val = (req0_val | req1_val) & ~w_full;
   assign memreq_msg = (w_winner == TAG_REQ1) ? req1_msg : req0_msg;
   assign w_fire     = memreq_val & memreq_rdy;
   assign req0_rdy   = w_fire & (w_winner == TAG_REQ0);
   assign req1_rdy   = w_fire & (w_winner == TAG_REQ1);

   assign w_pop      = memresp_val & ~w_empty;
   assign resp0_val  = w_pop & (w_head == TAG_REQ0);
   assign resp1_val  = w_pop & (w_head == TAG_REQ1);
   assign resp0_msg  = memresp_msg;
   assign resp1_msg  = memresp_msg;
   assign inflight   = w_count;
   assign err_orphan = r_err_orphan;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                    r_err_orphan <= 1'b0;
      else if (memresp_val && w_empty) r_err_orphan <= 1'b1;
   end

   riscv_mem_port_arb_tagq #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_tagq (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_fire),
      .i_tag   (w_winner),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

endmodule

// File: tb/tb_riscv_mem_port_arb.sv
// Directed bench for riscv_mem_port_arb (round-robin build, DEPTH=4).
module tb_riscv_mem_port_arb;
   localparam int REQ_SZ  = 67;
   localparam int RESP_SZ = 35;
   localparam int DEPTH   = 4;
   localparam int W       = 67;

   logic               clk = 1'b0;
   logic               reset_n;
   logic [REQ_SZ-1:0]  req0_msg, req1_msg, memreq_msg;
   logic               req0_val, req1_val, req0_rdy, req1_rdy;
   logic [RESP_SZ-1:0] resp0_msg, resp1_msg, memresp_msg;
   logic               resp0_val, resp1_val;
   logic               memreq_val, memreq_rdy, memresp_val;
   logic [2:0]         inflight;
   logic               err_orphan;

   int n_chk = 0;
   int n_err = 0;

   riscv_mem_port_arb #(.REQ_SZ(REQ_SZ), .RESP_SZ(RESP_SZ), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0_msg(req0_msg), .req0_val(req0_val), .req0_rdy(req0_rdy),
      .req1_msg(req1_msg), .req1_val(req1_val), .req1_rdy(req1_rdy),
      .resp0_msg(resp0_msg), .resp0_val(resp0_val),
      .resp1_msg(resp1_msg), .resp1_val(resp1_val),
      .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
      .memresp_msg(memresp_msg), .memresp_val(memresp_val),
      .inflight(inflight), .err_orphan(err_orphan)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      req0_msg = '0; req1_msg = '0; req0_val = 1'b0; req1_val = 1'b0;
      memreq_rdy = 1'b0; memresp_msg = '0; memresp_val = 1'b0;
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      chk("rst_inflight", W'(inflight), W'(0));
      chk("rst_err", W'(err_orphan), W'(0));
      chk("rst_rdy0", W'(req0_rdy), W'(0));
      chk("rst_rdy1", W'(req1_rdy), W'(0));
      chk("rst_memval", W'(memreq_val), W'(0));
      chk("rst_resp", W'({resp0_val, resp1_val}), W'(0));
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1;

      // single requester round trip
      req0_msg = 67'h100; req0_val = 1'b1; memreq_rdy = 1'b1;
      #1;
      chk("t1_memval", W'(memreq_val), W'(1));
      chk("t1_memmsg", memreq_msg, 67'h100);
      chk("t1_rdy0", W'(req0_rdy), W'(1));
      chk("t1_rdy1", W'(req1_rdy), W'(0));
      chk("t1_infl0", W'(inflight), W'(0));
      step();
      req0_val = 1'b0;
      #1;
      chk("t1_infl1", W'(inflight), W'(1));
      memresp_msg = 35'h0deadbeef; memresp_val = 1'b1;
      #1;
      chk("t1_resp0", W'(resp0_val), W'(1));
      chk("t1_resp1", W'(resp1_val), W'(0));
      chk("t1_rmsg", W'(resp0_msg), W'(35'h0deadbeef));
      step();
      memresp_val = 1'b0;
      #1;
      chk("t1_infl_end", W'(inflight), W'(0));

      // both requesters every cycle, one response per cycle behind
      for (int i = 0; i < 6; i++) begin
         req0_val = 1'b1; req1_val = 1'b1;
         req0_msg = 67'(16'h2000 + i); req1_msg = 67'(16'h3000 + i);
         memresp_val = (i > 0);
         #1;
         chk($sformatf("t2_rdy0_%0d", i), W'(req0_rdy), W'(i % 2 == 0));
         chk($sformatf("t2_rdy1_%0d", i), W'(req1_rdy), W'(i % 2 == 1));
         chk($sformatf("t2_msg_%0d", i), memreq_msg,
             (i % 2 == 1) ? 67'(16'h3000 + i) : 67'(16'h2000 + i));
         if (i > 0) begin
            chk($sformatf("t2_resp0_%0d", i), W'(resp0_val), W'((i - 1) % 2 == 0));
            chk($sformatf("t2_resp1_%0d", i), W'(resp1_val), W'((i - 1) % 2 == 1));
            chk($sformatf("t2_infl_%0d", i), W'(inflight), W'(1));
         end
         step();
      end
      req0_val = 1'b0; req1_val = 1'b0; memresp_val = 1'b1;
      #1;
      chk("t2_last_resp1", W'(resp1_val), W'(1));
      chk("t2_last_resp0", W'(resp0_val), W'(0));
      step();
      memresp_val = 1'b0;
      #1;
      chk("t2_infl_end", W'(inflight), W'(0));

      // fill the tag queue, then check full blocking and resume
      req0_val = 1'b1;
      for (int i = 0; i < 4; i++) step();
      req1_val = 1'b1;
      #1;
      chk("t3_infl_full", W'(inflight), W'(4));
      chk("t3_memval", W'(memreq_val), W'(0));
      chk("t3_rdy0", W'(req0_rdy), W'(0));
      chk("t3_rdy1", W'(req1_rdy), W'(0));
      memresp_val = 1'b1;
      #1;
      chk("t3_nobypass_val", W'(memreq_val), W'(0));
      chk("t3_nobypass_rdy0", W'(req0_rdy), W'(0));
      chk("t3_pop_resp0", W'(resp0_val), W'(1));
      step();
      memresp_val = 1'b0;
      #1;
      chk("t3_infl3", W'(inflight), W'(3));
      chk("t3_resume_val", W'(memreq_val), W'(1));
      chk("t3_resume_rdy0", W'(req0_rdy), W'(1));
      step();
      req0_val = 1'b0; req1_val = 1'b0;
      #1;
      chk("t3_refill", W'(inflight), W'(4));
      memresp_val = 1'b1;
      for (int i = 0; i < 4; i++) step();
      memresp_val = 1'b0;
      #1;
      chk("t3_drain", W'(inflight), W'(0));

      // grants 1,0,1 with responses two cycles behind
      req1_val = 1'b1;
      step();
      req1_val = 1'b0; req0_val = 1'b1;
      step();
      req0_val = 1'b0; req1_val = 1'b1; memresp_val = 1'b1;
      #1;
      chk("t4_a_resp1", W'(resp1_val), W'(1));
      chk("t4_a_resp0", W'(resp0_val), W'(0));
      chk("t4_a_rdy1", W'(req1_rdy), W'(1));
      step();
      req1_val = 1'b0;
      #1;
      chk("t4_pushpop_infl", W'(inflight), W'(2));
      chk("t4_b_resp0", W'(resp0_val), W'(1));
      chk("t4_b_resp1", W'(resp1_val), W'(0));
      step();
      #1;
      chk("t4_c_infl", W'(inflight), W'(1));
      chk("t4_c_resp1", W'(resp1_val), W'(1));
      step();
      memresp_val = 1'b0;
      #1;
      chk("t4_end_infl", W'(inflight), W'(0));

      // orphan response
      memresp_val = 1'b1;
      #1;
      chk("t5_resp", W'({resp0_val, resp1_val}), W'(0));
      step();
      memresp_val = 1'b0;
      #1;
      chk("t5_err", W'(err_orphan), W'(1));
      chk("t5_infl", W'(inflight), W'(0));
      step(); step();
      chk("t5_err_sticky", W'(err_orphan), W'(1));

      // async reset mid-stream; rr_ptr left at 1 before reset
      req0_val = 1'b1; req1_val = 1'b1;
      #1;
      chk("t6_tie_rdy1", W'(req1_rdy), W'(1));
      step();
      #1;
      chk("t6_tie_rdy0", W'(req0_rdy), W'(1));
      step();
      req1_val = 1'b0;
      step();
      req0_val = 1'b0;
      #1;
      chk("t6_infl3", W'(inflight), W'(3));
      reset_n = 1'b0;
      #1;
      chk("t6_rst_infl", W'(inflight), W'(0));
      chk("t6_rst_err", W'(err_orphan), W'(0));
      step();
      reset_n = 1'b1;
      req0_val = 1'b1; req1_val = 1'b1;
      #1;
      chk("t6_post_rdy0", W'(req0_rdy), W'(1));
      chk("t6_post_rdy1", W'(req1_rdy), W'(0));
      step();
      req0_val = 1'b0; req1_val = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
